// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types for the iterative multiply/divide sequencer
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ITER_W        = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - core <-> multiply/divide sequencer signal bundle
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step_unit.sv
// rtl/muldiv_step_unit.sv - one radix-2 shift-add (mult) or restoring shift-subtract (div) step
module muldiv_step_unit #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Mult: {acc,q} >>= 1 after adding b on q[0]; div: shift dividend bit into acc, subtract if it fits
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    shifted = {acc, q[WIDTH-1]};
    ge      = (shifted >= {1'b0, b});
    // when ge holds the true difference is below b, so WIDTH bits are enough
    diff    = shifted[WIDTH-1:0] - b;
    if (is_div) begin
      acc_nxt = ge ? diff : shifted[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU controller owning HI/LO; option MULDIV_EARLY_OUT_EN
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state, state_nxt;
  op_e                op_q;
  logic [WIDTH-1:0]   acc, q, b;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res, neg_rem;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_zero_q;
  logic               sgn, accept, run_last, busy;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   mrem;
`endif

  muldiv_step_unit #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  // Operand magnitudes and launch qualification; flush always wins over start
  always_comb begin
    sgn    = op_is_signed(bus.op);
    abs_rs = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    abs_rt = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
    accept = ((state == IDLE) || (state == DONE)) && bus.start && !bus.flush;
    run_last = (cnt == LAST);
`ifdef MULDIV_EARLY_OUT_EN
    // the step in flight consumes mrem[0]; stop once nothing above it remains
    if (!op_is_div(op_q) && ((mrem >> 1) == '0)) run_last = 1'b1;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = (state == RUN) || (state == FIX);
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (run_last) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Sign correction of the raw magnitude results
  always_comb begin
    prod = {acc, q};
`ifdef MULDIV_EARLY_OUT_EN
    // an early exit leaves the product high by the number of skipped steps
    prod = prod >> (CNT_W'(WIDTH) - cnt);
`endif
    if (neg_res) prod = -prod;
    fix_hi = neg_rem ? -acc : acc;
    fix_lo = neg_res ? -q : q;
    if (b == '0) fix_lo = '1;
  end

  // Operand capture at launch, one iteration per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MULT;
      acc     <= '0;
      q       <= '0;
      b       <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      mrem    <= '0;
`endif
    end else if (accept) begin
      op_q    <= bus.op;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= sgn & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
      neg_rem <= sgn & bus.rs_data[WIDTH-1];
      q       <= op_is_div(bus.op) ? abs_rs : abs_rt;
      b       <= op_is_div(bus.op) ? abs_rt : abs_rs;
`ifdef MULDIV_EARLY_OUT_EN
      mrem    <= abs_rt;
`endif
    end else if (state == RUN) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      cnt <= cnt + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
      mrem <= mrem >> 1;
`endif
    end
  end

  // HI/LO and div_zero: result writeback on DONE entry, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else if ((state == FIX) && !bus.flush) begin
      hi_q       <= op_is_div(op_q) ? fix_hi : prod[2*WIDTH-1:WIDTH];
      lo_q       <= op_is_div(op_q) ? fix_lo : prod[WIDTH-1:0];
      div_zero_q <= op_is_div(op_q) && (b == '0);
    end else begin
      if (accept) div_zero_q <= 1'b0;
      if (!busy && bus.hi_we) hi_q <= bus.wdata;
      if (!busy && bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state == DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   ndone;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // launch one op from a negedge; returns the cycle index (start cycle = 0) where done is seen
  task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] d, output int c);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = d;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (bus.done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_max_latency: got %0d want 34", cyc); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi: got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo: got %h want 00000001", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_max_busy_in_done: got %b want 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_max_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_mult_signed;
    @(negedge clk);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, cyc);
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", bus.lo); end
  endtask

  task automatic test_divu;
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL divu_latency: got %0d want 34", cyc); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_quot: got %h want 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_rem: got %h want 00000002", bus.hi); end
  endtask

  task automatic test_div_signed;
    @(negedge clk);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_quot: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_rem: got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_div_zero;
    @(negedge clk);
    run_op(OP_DIV, 32'd5, 32'd0, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div0_latency: got %0d want 34", cyc); end
    checks++; if (bus.hi !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h want 00000005", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", bus.lo); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL div0_flag: got %b want 1", bus.div_zero); end
  endtask

  task automatic test_div_overflow;
    @(negedge clk);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_quot: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_rem: got %h want 00000000", bus.hi); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_flag: got %b want 0", bus.div_zero); end
  endtask

  task automatic test_multu_small;
    int want_max;
    @(negedge clk);
    run_op(OP_MULTU, 32'd5, 32'd3, cyc);
`ifdef MULDIV_EARLY_OUT_EN
    want_max = 5;
`else
    want_max = 34;
`endif
    checks++; if (cyc > want_max || cyc < 3 || (want_max == 34 && cyc != 34)) begin errors++; $display("FAIL multu_small_latency: got %0d want <= %0d", cyc, want_max); end
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL multu_small_lo: got %h want 0000000f", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL multu_small_hi: got %h want 00000000", bus.hi); end
  endtask

  task automatic test_start_while_busy;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd6; bus.rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    checks++; if (cyc !== 34) begin errors++; $display("FAIL busy_start_latency: got %0d want 34", cyc); end
    checks++; if (bus.hi !== 32'd5) begin errors++; $display("FAIL busy_start_hi: got %h want 00000005", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL busy_start_lo: got %h want fffffffa", bus.lo); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_not_queued: got %b want 0", bus.busy); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'hFFFFFFFF; bus.rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", bus.busy); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
    checks++; if (bus.hi !== 32'd5) begin errors++; $display("FAIL flush_hi_kept: got %h want 00000005", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL flush_lo_kept: got %h want fffffffa", bus.lo); end
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got %b want 0", bus.busy); end
  endtask

  task automatic test_hi_lo_write;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_idle: got %h want 12345678", bus.hi); end
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'hFFFFFFFF;
    bus.lo_we = 1'b1; bus.wdata = 32'hAAAA5555;
    @(negedge clk);
    bus.start = 1'b0; bus.lo_we = 1'b0;
    cyc = 1;
    checks++; if (bus.lo !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_with_start: got %h want aaaa5555", bus.lo); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_with_mtlo: got %b want 1", bus.busy); end
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    cyc++;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_busy_ignored: got %h want 12345678", bus.hi); end
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL write_then_result_hi: got %h want 00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL write_then_result_lo: got %h want fffffffe", bus.lo); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_quot: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_rem: got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'hFFFFFFFF; bus.rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL async_rst_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL async_rst_lo: got %h want 0", bus.lo); end
    checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL async_rst_flags: got done=%b div_zero=%b want 0 0", bus.done, bus.div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_multu_small();
    test_start_while_busy();
    test_flush();
    test_hi_lo_write();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
